ddr3_port_arbiter: RTL
======================

# ddr3_port_arbiter

Two-port arbiter that shares the single DDR3MI application interface (command, write-data and read-data channels) between two DMA masters: port 0 is the video frame buffer, port 1 is the CV accelerator DMA. It sits in the `I_dma_clk` domain, between the masters and the DDR3 controller. It grants commands round-robin, with an urgent override for port 0. It holds the grant through a write burst and steers returned read data to the requester that issued the read.

## Interface
- ADDR_WIDTH, 28, DDR3 app address width
- DATA_WIDTH, 128, app data width
- BURST_W, 6, width of app_burst_number (beats = value + 1)
- TAG_DEPTH, 8, outstanding-read tracking FIFO depth (power of 2)

- I_dma_clk  in  1  controller user clock; everything is synchronous to it
- I_rst_n  in  1  asynchronous, active-low reset
- I_m{0,1}_cmd_en  in  1  command valid from master N
- I_m{0,1}_cmd  in  3  0 = write, 1 = read; other codes are an error
- I_m{0,1}_addr  in  ADDR_WIDTH  burst start address
- I_m{0,1}_burst_number  in  BURST_W  beats - 1
- O_m{0,1}_cmd_ready  out  1  command accepted when high together with cmd_en
- I_m{0,1}_wr_data_en / I_m{0,1}_wr_data_end  in  1  write beat valid / last beat
- I_m{0,1}_wr_data  in  DATA_WIDTH;  I_m{0,1}_wr_data_mask  in  DATA_WIDTH/8
- O_m{0,1}_wr_data_rdy  out  1  write beat accepted
- O_m{0,1}_rd_data_valid  out  1;  O_m{0,1}_rd_data  out  DATA_WIDTH  returned read beats
- I_m0_urgent  in  1  frame-buffer FIFO near empty/full; port 0 wins the next grant
- O_cmd / O_cmd_en / O_addr / O_app_burst_number  out  to DDR3MI
- I_cmd_ready  in  1;  I_wr_data_rdy  in  1
- O_wr_data_en / O_wr_data_end / O_wr_data / O_wr_data_mask  out  to DDR3MI
- I_rd_data_valid  in  1;  I_rd_data  in  DATA_WIDTH
- O_err  out  1  sticky protocol error
- O_busy  out  1  high when not IDLE or tag FIFO not empty

## Operation
- Clocking and reset are fixed: single clock `I_dma_clk`; `I_rst_n` is asynchronous and active-low.
- **FSM states:**
  - IDLE: select `gnt`, the winner among ports with cmd_en high.
    - Urgent rule: `I_m0_urgent` and m0 requesting gives port 0.
    - Otherwise the port that did not win last (`last` register) has priority.
  - Command pass-through in IDLE: the command from `gnt` is muxed combinationally to O_cmd*.
    - `O_mN_cmd_ready = (gnt==N) & I_cmd_ready & !(read & tag_full)`.
    - O_cmd_en is the granted cmd_en, gated by the same condition.
  - Accepted write: go to WDATA, load `beats = burst_number + 1`, set `last <= gnt`.
  - Accepted read: push {port, burst_number} into the tag FIFO, set `last <= gnt`, stay in IDLE.
  - WDATA: the grant is locked.
    - The write channel of the owner passes through: `O_mN_wr_data_rdy = I_wr_data_rdy` for the owner only.
    - Each accepted beat (en & rdy) decrements `beats`.
    - The accepted beat with `beats == 1` returns to IDLE.
    - If wr_data_end disagrees with `beats == 1`, O_err is set; the FSM follows the counter, not wr_data_end.
    - No commands are granted in WDATA.
- **Read return:** each I_rd_data_valid beat is routed to the port at the tag FIFO head.
  - I_rd_data is fanned out to both ports; only the owner sees valid.
  - A head beat counter counts to burst_number + 1, then pops the FIFO.
  - I_rd_data_valid with the FIFO empty: O_err is set and the beat is dropped.
- **Error sources:** illegal cmd code (>1) is accepted, then ignored (not forwarded) and sets O_err. O_err clears only on reset.

## Timing
- Command path: zero-cycle combinational mux. The grant decision is registered through `last`/state, so there is no combinational loop from cmd_ready back to cmd_en selection.
- Write data path: zero-latency pass-through. Read return: zero-latency routing (head tag is registered).
- Reset values: state IDLE, `last` = 1 (port 0 wins first), tag FIFO empty, O_err 0, O_busy 0, all O_* valid/enable outputs 0.
- A read command accept and a read beat that pops the FIFO in the same cycle: push and pop both occur. Full is evaluated before the pop, so a full FIFO blocks reads that cycle.
- Reset mid-burst aborts; no beats are replayed.
- Back-to-back commands from the same port are allowed only if the other port is idle.

## Structure
- Package `ddr3_arb_pkg`: command codes (CMD_WR=0, CMD_RD=1), state enum {IDLE, WDATA}, tag struct {port, burst_number}.
- Sub-module `ddr3_arb_tag_fifo`: synchronous FIFO of width 1+BURST_W, depth TAG_DEPTH, with full/empty flags.

## Test plan
- Both ports request reads, urgent=0, four rounds → grants alternate 0,1,0,1 starting with port 0; rd beats route to the matching port in issue order.
- m1 writes burst_number=3 while m0 requests → m0 cmd_ready stays 0 for exactly 4 accepted beats, then m0 is granted.
- I_wr_data_rdy toggles every other cycle during an 8-beat write → exactly 8 beats forwarded, O_wr_data_end on beat 8, FSM back to IDLE.
- 8 outstanding reads with TAG_DEPTH=8 → 9th read cmd_ready=0 until the first read's last beat arrives; then it is accepted.
- I_m0_urgent=1 with last winner = 0 and both requesting → port 0 granted again.
- Spurious I_rd_data_valid with empty FIFO, and wr_data_end asserted on beat 2 of 4 → O_err=1, no data delivered to either port, beat count unaffected.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the two-port DDR3 application-interface arbiter.
package ddr3_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    // Tag width is fixed here; the arbiter's BURST_W must match it.
    localparam int TAG_BN_W = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } state_t;

    typedef struct packed {
        logic                port;
        logic [TAG_BN_W-1:0] burst_number;
    } tag_t;

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Outstanding-read tag FIFO: head entry is read straight from registered storage.
module ddr3_arb_tag_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          push_ok, pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 app interface between the video frame buffer (port 0) and CV DMA (port 1):
// round-robin command grant with urgent override, write-burst lock, tagged read-data return.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int BURST_W    = TAG_BN_W,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                    I_dma_clk,
    input  logic                    I_rst_n,
    input  logic                    I_m0_cmd_en,
    input  logic [2:0]              I_m0_cmd,
    input  logic [ADDR_WIDTH-1:0]   I_m0_addr,
    input  logic [BURST_W-1:0]      I_m0_burst_number,
    output logic                    O_m0_cmd_ready,
    input  logic                    I_m0_wr_data_en,
    input  logic                    I_m0_wr_data_end,
    input  logic [DATA_WIDTH-1:0]   I_m0_wr_data,
    input  logic [DATA_WIDTH/8-1:0] I_m0_wr_data_mask,
    output logic                    O_m0_wr_data_rdy,
    output logic                    O_m0_rd_data_valid,
    output logic [DATA_WIDTH-1:0]   O_m0_rd_data,
    input  logic                    I_m0_urgent,
    input  logic                    I_m1_cmd_en,
    input  logic [2:0]              I_m1_cmd,
    input  logic [ADDR_WIDTH-1:0]   I_m1_addr,
    input  logic [BURST_W-1:0]      I_m1_burst_number,
    output logic                    O_m1_cmd_ready,
    input  logic                    I_m1_wr_data_en,
    input  logic                    I_m1_wr_data_end,
    input  logic [DATA_WIDTH-1:0]   I_m1_wr_data,
    input  logic [DATA_WIDTH/8-1:0] I_m1_wr_data_mask,
    output logic                    O_m1_wr_data_rdy,
    output logic                    O_m1_rd_data_valid,
    output logic [DATA_WIDTH-1:0]   O_m1_rd_data,
    output logic [2:0]              O_cmd,
    output logic                    O_cmd_en,
    output logic [ADDR_WIDTH-1:0]   O_addr,
    output logic [BURST_W-1:0]      O_app_burst_number,
    input  logic                    I_cmd_ready,
    input  logic                    I_wr_data_rdy,
    output logic                    O_wr_data_en,
    output logic                    O_wr_data_end,
    output logic [DATA_WIDTH-1:0]   O_wr_data,
    output logic [DATA_WIDTH/8-1:0] O_wr_data_mask,
    input  logic                    I_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]   I_rd_data,
    output logic                    O_err,
    output logic                    O_busy
);
    state_t             state;
    logic               last, owner, err;
    logic [BURST_W:0]   beats;
    logic [BURST_W-1:0] rd_cnt;

    logic               gnt, gnt_vld, cmd_acc;
    logic               is_rd, is_wr, illegal;
    logic [2:0]         sel_cmd;
    logic [BURST_W-1:0] sel_bn;

    logic               own_en, own_end, in_wr, wbeat, wlast;
    logic               rd_hit, rd_last;
    logic               push, pop, tag_full, tag_empty;
    tag_t               push_tag, head;

    // Grant depends only on registered state and the request lines, never on cmd_ready.
    always_comb begin
        gnt_vld = (state == ST_IDLE) & (I_m0_cmd_en | I_m1_cmd_en);
        if (I_m0_urgent & I_m0_cmd_en)      gnt = 1'b0;
        else if (I_m0_cmd_en & I_m1_cmd_en) gnt = ~last;
        else                                gnt = I_m1_cmd_en;
    end

    assign sel_cmd = gnt ? I_m1_cmd : I_m0_cmd;
    assign sel_bn  = gnt ? I_m1_burst_number : I_m0_burst_number;
    assign is_rd   = (sel_cmd == CMD_RD);
    assign is_wr   = (sel_cmd == CMD_WR);
    assign illegal = ~is_rd & ~is_wr;
    assign cmd_acc = gnt_vld & I_cmd_ready & ~(is_rd & tag_full);

    assign O_m0_cmd_ready     = cmd_acc & ~gnt;
    assign O_m1_cmd_ready     = cmd_acc & gnt;
    assign O_cmd_en           = cmd_acc & ~illegal;
    assign O_cmd              = sel_cmd;
    assign O_addr             = gnt ? I_m1_addr : I_m0_addr;
    assign O_app_burst_number = sel_bn;

    assign push                  = cmd_acc & is_rd;
    assign push_tag.port         = gnt;
    assign push_tag.burst_number = TAG_BN_W'(sel_bn);

    // Write channel: owner passes through; burst end comes from our own beat counter.
    assign in_wr   = (state == ST_WDATA);
    assign own_en  = owner ? I_m1_wr_data_en  : I_m0_wr_data_en;
    assign own_end = owner ? I_m1_wr_data_end : I_m0_wr_data_end;
    assign wlast   = (beats == (BURST_W+1)'(1));

    assign O_wr_data_en     = in_wr & own_en;
    assign O_wr_data_end    = O_wr_data_en & wlast;
    assign O_wr_data        = owner ? I_m1_wr_data : I_m0_wr_data;
    assign O_wr_data_mask   = owner ? I_m1_wr_data_mask : I_m0_wr_data_mask;
    assign O_m0_wr_data_rdy = in_wr & ~owner & I_wr_data_rdy;
    assign O_m1_wr_data_rdy = in_wr & owner & I_wr_data_rdy;
    assign wbeat            = O_wr_data_en & I_wr_data_rdy;

    assign rd_hit  = I_rd_data_valid & ~tag_empty;
    assign rd_last = (TAG_BN_W'(rd_cnt) == head.burst_number);
    assign pop     = rd_hit & rd_last;

    assign O_m0_rd_data_valid = rd_hit & ~head.port;
    assign O_m1_rd_data_valid = rd_hit & head.port;
    assign O_m0_rd_data       = I_rd_data;
    assign O_m1_rd_data       = I_rd_data;

    assign O_err  = err;
    assign O_busy = in_wr | ~tag_empty;

    always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state  <= ST_IDLE;
            last   <= 1'b1;
            owner  <= 1'b0;
            beats  <= '0;
            rd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (cmd_acc) begin
                if (!illegal) last <= gnt;
                if (is_wr) begin
                    state <= ST_WDATA;
                    owner <= gnt;
                    beats <= {1'b0, sel_bn} + (BURST_W+1)'(1);
                end
            end
            if (wbeat) begin
                beats <= beats - (BURST_W+1)'(1);
                if (wlast) state <= ST_IDLE;
            end
            if (rd_hit) rd_cnt <= rd_last ? '0 : rd_cnt + BURST_W'(1);
            if ((cmd_acc & illegal) | (wbeat & (own_end != wlast)) | (I_rd_data_valid & tag_empty))
                err <= 1'b1;
        end
    end

    ddr3_arb_tag_fifo #(
        .W     ($bits(tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (I_dma_clk),
        .rst_n (I_rst_n),
        .push  (push),
        .din   (push_tag),
        .pop   (pop),
        .dout  (head),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule
